// File: rtl/fc_stream_host.sv
// Host-side driver/collector for an fc layer: streams an N-element vector out over
// a valid/ready port, then gathers M results into a readable result file.
module fc_stream_host #(
   parameter int unsigned M = 8,
   parameter int unsigned N = 10,
   parameter int unsigned T = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        load_en,
   input  logic        [$clog2(N)-1:0] load_addr,
   input  logic signed [T-1:0]         load_data,
   input  logic                        start,
   output logic                        tx_valid,
   input  logic                        tx_ready,
   output logic signed [T-1:0]         tx_data,
   input  logic                        rx_valid,
   output logic                        rx_ready,
   input  logic signed [T-1:0]         rx_data,
   input  logic        [$clog2(M)-1:0] rd_addr,
   output logic signed [T-1:0]         rd_data,
   output logic                        busy,
   output logic                        done
);

   localparam int unsigned NW = $clog2(N);
   localparam int unsigned MW = $clog2(M);
   localparam int unsigned RdDepth = 2 ** MW;

   typedef enum logic [1:0] {StIdle, StSend, StRecv, StDone} state_e;

   state_e              state;
   logic signed [T-1:0] vec [N];
   logic signed [T-1:0] result [M];
   logic [NW-1:0]       tx_idx;
   logic [NW-1:0]       tx_next;
   logic [MW-1:0]       rx_idx;
   logic                idle_like;
   logic                load_ok;
   logic signed [T-1:0] rd_table [RdDepth];

   assign idle_like = (state == StIdle) || (state == StDone);
   assign tx_next   = tx_idx + NW'(1);

   // A load in the same cycle as an accepted start is dropped.
   assign load_ok = idle_like && !start && load_en &&
                    ({{(32-NW){1'b0}}, load_addr} < N);

   // Vector buffer survives reset on purpose.
   always_ff @(posedge clk) begin
      if (load_ok) begin
         vec[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= StIdle;
         tx_valid <= 1'b0;
         tx_data  <= '0;
         rx_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         tx_idx   <= '0;
         rx_idx   <= '0;
         for (int i = 0; i < int'(M); i++) begin
            result[i] <= '0;
         end
      end else begin
         unique case (state)
            StIdle, StDone: begin
               if (start) begin
                  state    <= StSend;
                  tx_valid <= 1'b1;
                  tx_data  <= vec[0];
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  tx_idx   <= '0;
                  rx_idx   <= '0;
               end
            end
            StSend: begin
               if (tx_ready) begin
                  if (tx_idx == NW'(N - 1)) begin
                     tx_valid <= 1'b0;
                     rx_ready <= 1'b1;
                     state    <= StRecv;
                  end else begin
                     tx_idx  <= tx_next;
                     tx_data <= vec[tx_next];
                  end
               end
            end
            StRecv: begin
               if (rx_valid) begin
                  result[rx_idx] <= rx_data;
                  if (rx_idx == MW'(M - 1)) begin
                     rx_ready <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     state    <= StDone;
                  end else begin
                     rx_idx <= rx_idx + MW'(1);
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   // Addresses beyond M read as zero.
   always_comb begin
      for (int i = 0; i < int'(RdDepth); i++) begin
         rd_table[i] = '0;
      end
      for (int i = 0; i < int'(M); i++) begin
         rd_table[i] = result[i];
      end
      rd_data = rd_table[rd_addr];
   end

endmodule

// File: tb/tb_fc_stream_host.sv
// Directed bench for fc_stream_host; the bench itself plays the layer on the tx/rx ports.
module tb_fc_stream_host;

   localparam int M = 8;
   localparam int N = 10;
   localparam int T = 16;

   logic                clk = 1'b0;
   logic                reset;
   logic                load_en;
   logic [3:0]          load_addr;
   logic signed [T-1:0] load_data;
   logic                start;
   logic                tx_valid;
   logic                tx_ready;
   logic signed [T-1:0] tx_data;
   logic                rx_valid;
   logic                rx_ready;
   logic signed [T-1:0] rx_data;
   logic [2:0]          rd_addr;
   logic signed [T-1:0] rd_data;
   logic                busy;
   logic                done;

   always #5 clk = ~clk;

   fc_stream_host #(.M(M), .N(N), .T(T)) dut (
      .clk       (clk),
      .reset     (reset),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data),
      .start     (start),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .rx_data   (rx_data),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .busy      (busy),
      .done      (done)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic signed [T-1:0] tx_q [$];
   logic signed [T-1:0] res_q [$];
   logic signed [T-1:0] vec_model [N];
   logic signed [T-1:0] res_model [M];
   logic signed [T-1:0] xs [N];
   logic signed [T-1:0] drv_v [M];
   logic signed [T-1:0] exp_v [M];
   logic signed [T-1:0] wcol0 [M] = '{122, 39, -80, 13, 111, -63, 59, -42};

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_checks = n_checks + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_model();
      for (int i = 0; i < N; i++) begin
         load_en   = 1'b1;
         load_addr = 4'(i);
         load_data = vec_model[i];
         tick();
      end
      load_en = 1'b0;
   endtask

   // noise: rx_valid, start and load_en are all asserted while sending.
   task automatic run_send(input bit alt, input bit noise);
      int cyc;
      int xf;
      for (int i = 0; i < N; i++) tx_q.push_back(vec_model[i]);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy", busy, 1);
      check("start_done", done, 0);
      cyc = 0;
      xf  = 0;
      while (xf < N && cyc < 100) begin
         tx_ready = alt ? (cyc % 2 == 0) : 1'b1;
         if (noise) begin
            rx_valid  = 1'b1;
            rx_data   = 16'sd99;
            start     = 1'b1;
            load_en   = 1'b1;
            load_addr = 4'd0;
            load_data = 16'sd77;
            rd_addr   = 3'd0;
            #0;
            check("send_rx_ready", rx_ready, 0);
            check("send_res0", rd_data, res_model[0]);
         end
         check("send_valid", tx_valid, 1);
         check("send_data", tx_data, tx_q[0]);
         if (tx_valid && tx_ready) begin
            xs[xf] = tx_data;
            void'(tx_q.pop_front());
            xf++;
         end
         tick();
         cyc++;
      end
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      start    = 1'b0;
      load_en  = 1'b0;
      check("send_xfers", xf, N);
      if (!alt) check("send_cycles", cyc, N);
      check("send_end_valid", tx_valid, 0);
      check("send_end_rx_ready", rx_ready, 1);
      tx_q.delete();
   endtask

   task automatic run_recv(input bit gaps, input bit noise);
      int  j;
      int  cyc;
      bit  xfer;
      j   = 0;
      cyc = 0;
      while (j < M && cyc < 300) begin
         rx_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         rx_data  = drv_v[j];
         if (noise) begin
            start     = 1'b1;
            load_en   = 1'b1;
            load_addr = 4'd0;
            load_data = 16'sd77;
         end
         check("recv_ready", rx_ready, 1);
         check("recv_busy", busy, 1);
         xfer = rx_valid && rx_ready;
         if (xfer) begin
            res_q.push_back(exp_v[j]);
            res_model[j] = exp_v[j];
         end
         tick();
         cyc++;
         if (xfer) j++;
      end
      rx_valid = 1'b0;
      start    = 1'b0;
      load_en  = 1'b0;
      check("recv_beats", j, M);
      check("recv_done", done, 1);
      check("recv_busy_low", busy, 0);
      check("recv_ready_low", rx_ready, 0);
      tick();
      check("done_hold", done, 1);
      for (int a = 0; a < M; a++) begin
         rd_addr = 3'(a);
         #1;
         if (res_q.size() > 0) check("rd_data", rd_data, res_q.pop_front());
      end
      res_q.delete();
   endtask

   initial begin
      int acc;
      reset     = 1'b0;
      load_en   = 1'b0;
      load_addr = '0;
      load_data = '0;
      start     = 1'b0;
      tx_ready  = 1'b0;
      rx_valid  = 1'b0;
      rx_data   = '0;
      rd_addr   = '0;
      for (int i = 0; i < M; i++) res_model[i] = '0;

      tick();
      tick();
      check("rst_tx_valid", tx_valid, 0);
      check("rst_rx_ready", rx_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_data", rd_data, 0);
      reset = 1'b1;
      tick();

      // Vector 1..10, full-rate send, then gappy receive of -5..2
      for (int i = 0; i < N; i++) vec_model[i] = 16'(i + 1);
      load_model();
      run_send(1'b0, 1'b0);
      for (int i = 0; i < M; i++) begin
         drv_v[i] = 16'(i - 5);
         exp_v[i] = 16'(i - 5);
      end
      run_recv(1'b1, 1'b0);

      // Alternating tx_ready stalls
      run_send(1'b1, 1'b0);
      for (int i = 0; i < M; i++) begin
         drv_v[i] = 16'(100 + i);
         exp_v[i] = 16'(100 + i);
      end
      run_recv(1'b0, 1'b0);

      // Spurious rx_valid/start/load_en while busy
      run_send(1'b0, 1'b1);
      for (int i = 0; i < M; i++) begin
         drv_v[i] = 16'(i - 5);
         exp_v[i] = 16'(i - 5);
      end
      run_recv(1'b1, 1'b1);

      // Reset on the 4th SEND cycle
      start = 1'b1;
      tick();
      start    = 1'b0;
      tx_ready = 1'b1;
      tick();
      tick();
      tick();
      reset = 1'b0;
      tick();
      reset    = 1'b1;
      tx_ready = 1'b0;
      check("midrst_tx_valid", tx_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_rx_ready", rx_ready, 0);
      for (int a = 0; a < M; a++) begin
         rd_addr = 3'(a);
         #1;
         check("midrst_result", rd_data, 0);
         res_model[a] = '0;
      end
      run_send(1'b0, 1'b0);
      for (int i = 0; i < M; i++) begin
         drv_v[i] = 16'(3 * i - 7);
         exp_v[i] = 16'(3 * i - 7);
      end
      run_recv(1'b0, 1'b0);

      // Bench acts as the fc layer: y = W*x with x = unit vector e0
      for (int i = 0; i < N; i++) vec_model[i] = (i == 0) ? 16'sd1 : 16'sd0;
      load_model();
      run_send(1'b0, 1'b0);
      for (int m = 0; m < M; m++) begin
         acc = 0;
         for (int n = 0; n < N; n++) begin
            acc += ((n == 0) ? int'(wcol0[m]) : (m * 7 - n * 3)) * int'(xs[n]);
         end
         drv_v[m] = 16'(acc);
         exp_v[m] = wcol0[m];
      end
      run_recv(1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
